// File: rtl/cam_gen_pkg.sv
// Shared types and constants for the camera timing generator: FSM states,
// RGB565 colour-bar values and line/frame geometry helpers.
package cam_gen_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VSYNC  = 3'd1,
        VBACK  = 3'd2,
        ACTIVE = 3'd3,
        VFRONT = 3'd4
    } cam_state_e;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    // pclk periods in one complete line, active plus blank
    function automatic int line_len(input int h_active, input int h_blank, input int bpp);
        return (h_active + h_blank) * bpp;
    endfunction

    function automatic int max_lines(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic logic [15:0] bar_color(input logic [2:0] bar);
        logic [15:0] c;
        case (bar)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cam_pclk_div.sv
// Pixel-clock divider: pclk toggles every PCLK_HALF inclk cycles; fall_tick
// flags the inclk cycle whose edge drives pclk low.
module cam_pclk_div #(
    parameter int PCLK_HALF = 8
) (
    input  logic inclk,
    input  logic rst,
    output logic pclk,
    output logic fall_tick
);

    localparam int DIV_W = $clog2(PCLK_HALF) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PCLK_HALF - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             pclk_q, pclk_d;
    logic             toggle_s;

    // next divider count and pclk level
    always_comb begin
        toggle_s = (div_cnt_q == DIV_LAST);
        if (toggle_s) begin
            div_cnt_d = '0;
            pclk_d    = ~pclk_q;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
            pclk_d    = pclk_q;
        end
    end

    // divider state; pclk idles high out of reset
    always_ff @(posedge inclk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            pclk_q    <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            pclk_q    <= pclk_d;
        end
    end

    assign pclk      = pclk_q;
    assign fall_tick = toggle_s & pclk_q;

endmodule

// File: rtl/cam_timing_gen.sv
// OV-style camera source: frame/line framing plus a byte ramp, or RGB565
// colour bars when CAM_TIMING_GEN_COLORBAR_EN is defined.
module cam_timing_gen
    import cam_gen_pkg::*;
#(
    parameter int PCLK_HALF     = 8,
    parameter int BPP           = 2,
    parameter int H_ACTIVE      = 640,
    parameter int H_BLANK       = 144,
    parameter int V_SYNC_LINES  = 1,
    parameter int V_BACK_LINES  = 3,
    parameter int V_ACTIVE      = 480,
    parameter int V_FRONT_LINES = 10
) (
    input  logic        inclk,
    input  logic        rst,
    input  logic        en,
    output logic        pclk,
    output logic        href,
    output logic        vsync,
    output logic [7:0]  data,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int LINE   = line_len(H_ACTIVE, H_BLANK, BPP);
    localparam int MAXL   = max_lines(V_SYNC_LINES, V_BACK_LINES, V_ACTIVE, V_FRONT_LINES);
    localparam int BYTE_W = $clog2(LINE) + 1;
    localparam int LINE_W = $clog2(MAXL) + 1;

    localparam logic [BYTE_W-1:0] LAST_BYTE   = BYTE_W'(LINE - 1);
    localparam logic [BYTE_W-1:0] HREF_END    = BYTE_W'(H_ACTIVE * BPP);
    localparam logic [LINE_W-1:0] SYNC_LAST   = LINE_W'(V_SYNC_LINES - 1);
    localparam logic [LINE_W-1:0] BACK_LAST   = LINE_W'(V_BACK_LINES - 1);
    localparam logic [LINE_W-1:0] ACTIVE_LAST = LINE_W'(V_ACTIVE - 1);
    localparam logic [LINE_W-1:0] FRONT_LAST  = LINE_W'(V_FRONT_LINES - 1);

    cam_state_e        state_q, state_d;
    logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              href_q, href_d;
    logic              vsync_q, vsync_d;
    logic [7:0]        data_q, data_d;
    logic              frame_start_q, frame_start_d;
    logic              fall_tick_s;
    logic              last_byte_s;
    logic [7:0]        pattern_s;

    cam_pclk_div #(
        .PCLK_HALF (PCLK_HALF)
    ) u_div (
        .inclk     (inclk),
        .rst       (rst),
        .pclk      (pclk),
        .fall_tick (fall_tick_s)
    );

    // frame FSM and position counters; counters hold the position being presented
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        line_cnt_d    = line_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        frame_start_d = 1'b0;
        last_byte_s   = (byte_cnt_q == LAST_BYTE);
        if (fall_tick_s) begin
            if (last_byte_s) begin
                byte_cnt_d = '0;
                line_cnt_d = line_cnt_q + LINE_W'(1);
            end else begin
                byte_cnt_d = byte_cnt_q + BYTE_W'(1);
            end
            case (state_q)
                IDLE: begin
                    byte_cnt_d = '0;
                    line_cnt_d = '0;
                    if (en) begin
                        state_d       = VSYNC;
                        frame_start_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                VSYNC: begin
                    if (last_byte_s && (line_cnt_q == SYNC_LAST)) begin
                        state_d    = VBACK;
                        line_cnt_d = '0;
                    end else begin
                        state_d = VSYNC;
                    end
                end
                VBACK: begin
                    if (last_byte_s && (line_cnt_q == BACK_LAST)) begin
                        state_d    = ACTIVE;
                        line_cnt_d = '0;
                    end else begin
                        state_d = VBACK;
                    end
                end
                ACTIVE: begin
                    if (last_byte_s && (line_cnt_q == ACTIVE_LAST)) begin
                        state_d    = VFRONT;
                        line_cnt_d = '0;
                    end else begin
                        state_d = ACTIVE;
                    end
                end
                VFRONT: begin
                    if (last_byte_s && (line_cnt_q == FRONT_LAST)) begin
                        line_cnt_d  = '0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        if (en) begin
                            state_d       = VSYNC;
                            frame_start_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = VFRONT;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    byte_cnt_d = '0;
                    line_cnt_d = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

`ifdef CAM_TIMING_GEN_COLORBAR_EN
    logic [BYTE_W-1:0] pixel_s;
    logic [BYTE_W+2:0] pixel_x8_s;
    logic [2:0]        bar_s;
    logic [15:0]       color_s;

    // RGB565 bar byte for the next position, high byte first within a pixel
    always_comb begin
        pixel_s    = byte_cnt_d / BYTE_W'(BPP);
        pixel_x8_s = {pixel_s, 3'b000};
        bar_s      = 3'(pixel_x8_s / (BYTE_W + 3)'(H_ACTIVE));
        color_s    = bar_color(bar_s);
        if ((byte_cnt_d % BYTE_W'(BPP)) == '0) begin
            pattern_s = color_s[15:8];
        end else begin
            pattern_s = color_s[7:0];
        end
    end
`else
    // byte ramp restarting at 0x00 on every line
    always_comb begin
        pattern_s = byte_cnt_d[7:0];
    end
`endif

    // pixel-interface outputs follow the next position, launched with pclk fall
    always_comb begin
        href_d  = href_q;
        vsync_d = vsync_q;
        data_d  = data_q;
        if (fall_tick_s) begin
            vsync_d = (state_d == VSYNC);
            href_d  = (state_d == ACTIVE) && (byte_cnt_d < HREF_END);
            if (href_d) begin
                data_d = pattern_s;
            end else begin
                data_d = 8'h00;
            end
        end else begin
            href_d = href_q;
        end
    end

    // state and output registers
    always_ff @(posedge inclk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            byte_cnt_q    <= '0;
            line_cnt_q    <= '0;
            frame_cnt_q   <= 16'd0;
            href_q        <= 1'b0;
            vsync_q       <= 1'b0;
            data_q        <= 8'h00;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            line_cnt_q    <= line_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            href_q        <= href_d;
            vsync_q       <= vsync_d;
            data_q        <= data_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign href        = href_q;
    assign vsync       = vsync_q;
    assign data        = data_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
